// File: rtl/dtc_rr_sched.sv
// dtc_rr_sched: round-robin arbiter in front of one shared combinational
// classifier; registers the class code and owner id behind a valid/ready port.
module dtc_rr_sched #(
  parameter int N_REQ = 4,
  parameter int IN_W  = 11,
  parameter int OUT_W = 3,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*IN_W-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]       dt_inp,
  input  logic [OUT_W-1:0]      dt_outp,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OUT_W-1:0]      res_class,
  output logic [ID_W-1:0]       res_id,
  output logic                  busy,
  output logic [15:0]           done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_OUT
  } state_t;

  localparam logic [ID_W:0] NR = (ID_W+1)'(N_REQ);

  state_t           r_state;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  r_id;
  logic [IN_W-1:0]  r_feat;
  logic [OUT_W-1:0] r_class;
  logic             r_res_valid;
  logic             r_busy;
  logic [15:0]      r_done_cnt;

  logic             w_any;
  logic [ID_W-1:0]  w_win;
  logic [ID_W:0]    w_idx;
  logic [N_REQ-1:0] w_ready;
  logic [IN_W-1:0]  w_slice;

  // Search starts one past the last winner, so the last winner ranks lowest.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = {1'b0, r_last} + (ID_W+1)'(k);
      if (w_idx >= NR) w_idx = w_idx - NR;
      if (!w_any && req_valid[w_idx[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (rst_n && r_state == S_IDLE && w_any)
      w_ready[w_win] = 1'b1;
  end

  assign w_slice = req_data[w_win*IN_W +: IN_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= ID_W'(N_REQ-1);
      r_id        <= '0;
      r_feat      <= '0;
      r_class     <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_feat  <= w_slice;
            r_id    <= w_win;
            r_last  <= w_win;
            r_busy  <= 1'b1;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_class     <= dt_outp;
          r_res_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done_cnt  <= r_done_cnt + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign dt_inp    = r_feat;
  assign res_valid = r_res_valid;
  assign res_class = r_class;
  assign res_id    = r_id;
  assign busy      = r_busy;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_dtc_rr_sched.sv
// tb_dtc_rr_sched: scenario tasks plus randomized traffic against a
// transaction-level model of arbitration, latency and result handshake.
module tb_dtc_rr_sched;

  localparam int N   = 4;
  localparam int IW  = 11;
  localparam int OW  = 3;
  localparam int IDW = 2;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*IW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic [IW-1:0] dt_inp;
  logic [OW-1:0] dt_outp;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [OW-1:0] res_class;
  logic [IDW-1:0] res_id;
  logic          busy;
  logic [15:0]   done_cnt;

  int checks = 0;
  int errors = 0;

  // model: 0 = free, 1 = classifying, 2 = result presented
  int            m_ph   = 0;
  int            m_last = N-1;
  logic [IW-1:0] m_feat = '0;
  logic [OW-1:0] m_cls  = '0;
  logic [IDW-1:0] m_id  = '0;
  logic [15:0]   m_done = '0;
  logic [N-1:0]  e_ready = '0;

  assign dt_outp = dt_inp[OW-1:0];

  always #5 clk = ~clk;

  dtc_rr_sched #(
    .N_REQ(N),
    .IN_W (IW),
    .OUT_W(OW),
    .ID_W (IDW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .dt_inp   (dt_inp),
    .dt_outp  (dt_outp),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_class(res_class),
    .res_id   (res_id),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [37:0] obs();
    return {req_ready, res_valid, res_class, res_id, busy, dt_inp, done_cnt};
  endfunction

  function automatic logic [37:0] expv();
    return {e_ready, (m_ph == 2), m_cls, m_id, (m_ph != 0), m_feat, m_done};
  endfunction

  task automatic predict();
    #1;
    e_ready = '0;
    if (rst_n && m_ph == 0) begin
      int w;
      w = pick(req_valid, m_last);
      if (w >= 0) e_ready[w] = 1'b1;
    end
  endtask

  task automatic advance();
    int w;
    w = pick(req_valid, m_last);
    @(posedge clk);
    if (!rst_n) begin
      m_ph = 0; m_last = N-1; m_feat = '0;
      m_cls = '0; m_id = '0; m_done = '0;
    end else begin
      case (m_ph)
        0: if (w >= 0) begin
          m_feat = req_data[w*IW +: IW];
          m_id   = IDW'(w);
          m_last = w;
          m_ph   = 1;
        end
        1: begin
          m_cls = m_feat[OW-1:0];
          m_ph  = 2;
        end
        default: if (res_ready) begin
          m_ph   = 0;
          m_done = m_done + 16'd1;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; res_ready = 1'b1;
    req_data = 44'({$urandom, $urandom});
    advance();
    predict();
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", obs(), expv());
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0000", req_ready);
    end
    advance();
    rst_n = 1'b1; req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_data = '0;
    req_data[IW-1:0] = 11'h005; res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL single c%0d got %h exp %h", c, obs(), expv());
      end
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0001) begin
          errors++;
          $display("FAIL single_ready got %b exp 0001", req_ready);
        end
      end
      if (c == 2) begin
        checks++;
        if ({res_valid, res_class, res_id} !== {1'b1, 3'b101, 2'd0}) begin
          errors++;
          $display("FAIL single_res got %b/%b/%0d exp 1/101/0",
                   res_valid, res_class, res_id);
        end
      end
      advance();
      req_valid = '0;
    end
    checks++;
    if (done_cnt !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done got cnt %0d busy %b exp 1 0",
               done_cnt, busy);
    end
  endtask

  task automatic test_rr_all();
    int q_id[$];
    int q_cls[$];
    int q_cyc[$];
    int exp_id[5]  = '{0, 1, 2, 3, 0};
    int exp_cls[5] = '{1, 2, 3, 4, 1};
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1; req_valid = '1; res_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*IW +: IW] = IW'(i + 1);
    for (int c = 0; c < 15; c++) begin
      predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rr_all c%0d got %h exp %h", c, obs(), expv());
      end
      if (res_valid && res_ready) begin
        q_id.push_back(int'(res_id));
        q_cls.push_back(int'(res_class));
        q_cyc.push_back(c);
      end
      advance();
    end
    req_valid = '0;
    checks++;
    if (q_id.size() != 5) begin
      errors++;
      $display("FAIL rr_count got %0d exp 5", q_id.size());
    end
    for (int k = 0; k < 5 && k < q_id.size(); k++) begin
      checks++;
      if (q_id[k] != exp_id[k] || q_cls[k] != exp_cls[k] ||
          q_cyc[k] != 2 + 3*k) begin
        errors++;
        $display("FAIL rr_seq k%0d got id %0d cls %0d cyc %0d exp %0d %0d %0d",
                 k, q_id[k], q_cls[k], q_cyc[k], exp_id[k], exp_cls[k], 2 + 3*k);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [37:0] snap;
    snap = '0;
    predict();
    advance();
    req_valid = 4'b0010; res_ready = 1'b0;
    req_data = 44'({$urandom, $urandom});
    for (int c = 0; c < 13; c++) begin
      if (c == 12) begin
        req_valid = '0; res_ready = 1'b1;
      end
      predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL backpr c%0d got %h exp %h", c, obs(), expv());
      end
      if (c == 2) snap = obs();
      if (c == 11) begin
        checks++;
        if (obs() !== snap || req_ready !== 4'b0000) begin
          errors++;
          $display("FAIL backpr_hold got %h exp %h", obs(), snap);
        end
      end
      advance();
      if (c == 0) req_valid = '1;
    end
  endtask

  task automatic test_wrap();
    int grants[$];
    req_valid = 4'b0100; res_ready = 1'b1;
    req_data = 44'({$urandom, $urandom});
    for (int c = 0; c < 9; c++) begin
      predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL wrap c%0d got %h exp %h", c, obs(), expv());
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i]) grants.push_back(i);
      advance();
      req_valid = (c == 0 || c == 1) ? 4'b0000 : 4'b0101;
    end
    req_valid = '0;
    checks++;
    if (grants.size() != 3) begin
      errors++;
      $display("FAIL wrap_count got %0d exp 3", grants.size());
    end else begin
      checks++;
      if (grants[0] != 2 || grants[1] != 0 || grants[2] != 2) begin
        errors++;
        $display("FAIL wrap_order got %0d %0d %0d exp 2 0 2",
                 grants[0], grants[1], grants[2]);
      end
    end
    predict();
    advance();
  endtask

  task automatic test_reset_eval();
    req_valid = 4'b0001; res_ready = 1'b1;
    req_data = 44'({$urandom, $urandom});
    for (int c = 0; c < 5; c++) begin
      rst_n = (c != 1);
      predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rst_eval c%0d got %h exp %h", c, obs(), expv());
      end
      if (c >= 2) begin
        checks++;
        if (res_valid !== 1'b0 || done_cnt !== 16'd0) begin
          errors++;
          $display("FAIL rst_eval_out c%0d got v %b cnt %0d exp 0 0",
                   c, res_valid, done_cnt);
        end
      end
      advance();
      req_valid = '0;
    end
    rst_n = 1'b1; req_valid = '1;
    predict();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_eval_grant got %b exp 0001", req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      advance();
      req_valid = '0;
      predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rst_eval_tail c%0d got %h exp %h", c, obs(), expv());
      end
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(0, 79) != 0);
      req_valid = N'($urandom);
      req_data  = 44'({$urandom, $urandom});
      res_ready = ($urandom_range(0, 3) != 0);
      predict();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random c%0d got %h exp %h", c, obs(), expv());
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_done_wrap();
    req_valid = '0; res_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      predict();
      advance();
    end
    force dut.r_done_cnt = 16'hFFFE;
    m_done = 16'hFFFE;
    predict();
    advance();
    release dut.r_done_cnt;
    for (int t = 0; t < 2; t++) begin
      req_valid = 4'b1000;
      req_data = 44'({$urandom, $urandom});
      for (int c = 0; c < 3; c++) begin
        predict();
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL done_wrap t%0d c%0d got %h exp %h",
                   t, c, obs(), expv());
        end
        advance();
        req_valid = '0;
      end
      checks++;
      if (done_cnt !== (t == 0 ? 16'hFFFF : 16'h0000)) begin
        errors++;
        $display("FAIL done_wrap_cnt t%0d got %h exp %h",
                 t, done_cnt, (t == 0 ? 16'hFFFF : 16'h0000));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_all();
    test_backpressure();
    test_wrap();
    test_reset_eval();
    test_random();
    test_done_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
